sync_event_arbiter: RTL and testbench

SYNC_EVENT_ARBITER -- requirements
Module: sync_event_arbiter

---
 rtl/sync_event_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sync_event_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_event_arbiter.sv
// ---------------------------------------------------------------------------
// sync_event_arbiter
//   Brings CH_NUM asynchronous level inputs into the clk_i domain, turns each
//   rising edge into a pending event, and offers pending events downstream
//   one at a time. A round-robin pointer decides which channel goes next.
//
// Ports
//   clk_i        destination-domain clock, all logic on posedge
//   rst_n_i      asynchronous active-low reset
//   evt_async_i  [CH_NUM]   level inputs from foreign domains, rise = event
//   evt_valid_o  event offered downstream (high exactly while in OFFER)
//   evt_id_o     [ID_WIDTH] channel index of the offered event
//   evt_ready_i  downstream accept, transfer = evt_valid_o & evt_ready_i
//   pend_o       [CH_NUM]   per-channel pending flags
//   ovf_o        [CH_NUM]   per-channel sticky overflow flags
//   ovf_clr_i    synchronous clear of all ovf_o bits
// ---------------------------------------------------------------------------
module sync_event_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ID_WIDTH    = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CH_NUM-1:0]   evt_async_i,
  output logic                evt_valid_o,
  output logic [ID_WIDTH-1:0] evt_id_o,
  input  logic                evt_ready_i,
  output logic [CH_NUM-1:0]   pend_o,
  output logic [CH_NUM-1:0]   ovf_o,
  input  logic                ovf_clr_i
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Stage 0 samples the raw inputs; stage SYNC_STAGES-1 is the last one.
  logic [SYNC_STAGES-1:0][CH_NUM-1:0] sync_r;
  logic [CH_NUM-1:0]   dly_r;
  logic [CH_NUM-1:0]   pend_r;
  logic [CH_NUM-1:0]   ovf_r;
  state_t              state_r;
  logic                valid_r;
  logic [ID_WIDTH-1:0] evt_id_r;
  logic [ID_WIDTH-1:0] rr_ptr_r;

  logic [CH_NUM-1:0]   rise_s;
  logic [CH_NUM-1:0]   clr_s;
  logic [CH_NUM-1:0]   ovf_set_s;
  logic [CH_NUM-1:0]   pend_nxt_s;
  logic [CH_NUM-1:0]   ovf_nxt_s;
  logic                xfer_s;
  logic                grant_found_s;
  logic [ID_WIDTH-1:0] grant_id_s;

  // Synchronizer chains plus the delayed copy of the last stage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_r <= {(SYNC_STAGES*CH_NUM){1'b0}};
      dly_r  <= {CH_NUM{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], evt_async_i};
      dly_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  // Edge detect and next-state of the pending / overflow flags.
  // A coincident rise beats the transfer clear, and an overflow beats ovf_clr_i.
  always_comb begin
    rise_s     = sync_r[SYNC_STAGES-1] & ~dly_r;
    xfer_s     = valid_r & evt_ready_i;
    clr_s      = {CH_NUM{1'b0}};
    if (xfer_s) begin
      clr_s = {{(CH_NUM-1){1'b0}}, 1'b1} << evt_id_r;
    end else begin
      clr_s = {CH_NUM{1'b0}};
    end
    ovf_set_s  = rise_s & pend_r & ~clr_s;
    pend_nxt_s = (pend_r & ~clr_s) | rise_s;
    if (ovf_clr_i) begin
      ovf_nxt_s = ovf_set_s;
    end else begin
      ovf_nxt_s = ovf_r | ovf_set_s;
    end
  end

  // Pending and overflow flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_r <= {CH_NUM{1'b0}};
      ovf_r  <= {CH_NUM{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
      ovf_r  <= ovf_nxt_s;
    end
  end

  // Round-robin search: first pending channel at or above rr_ptr_r, wrapping.
  always_comb begin
    int                idx_v;
    logic [CH_NUM-1:0] rot_v;
    grant_found_s = 1'b0;
    grant_id_s    = {ID_WIDTH{1'b0}};
    idx_v         = 0;
    rot_v         = {CH_NUM{1'b0}};
    for (int i = 0; i < CH_NUM; i++) begin
      idx_v = (int'(rr_ptr_r) + i) % CH_NUM;
      rot_v = pend_r >> idx_v;
      if (!grant_found_s && rot_v[0]) begin
        grant_found_s = 1'b1;
        grant_id_s    = ID_WIDTH'(idx_v);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Offer FSM: IDLE picks a channel, OFFER holds it until accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r  <= IDLE;
      valid_r  <= 1'b0;
      evt_id_r <= {ID_WIDTH{1'b0}};
      rr_ptr_r <= {ID_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            state_r  <= OFFER;
            valid_r  <= 1'b1;
            evt_id_r <= grant_id_s;
          end else begin
            valid_r  <= 1'b0;
          end
        end
        OFFER: begin
          if (evt_ready_i) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            if (evt_id_r == ID_WIDTH'(CH_NUM - 1)) begin
              rr_ptr_r <= {ID_WIDTH{1'b0}};
            end else begin
              rr_ptr_r <= evt_id_r + {{(ID_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid_o = valid_r;
  assign evt_id_o    = evt_id_r;
  assign pend_o      = pend_r;
  assign ovf_o       = ovf_r;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sync_event_arbiter
//   Self-checking bench for sync_event_arbiter (CH_NUM=4, SYNC_STAGES=2).
//   Expected channel ids are queued when events are raised and popped when a
//   transfer is seen on the interface.
// ---------------------------------------------------------------------------
module tb_sync_event_arbiter;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int IW = 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [CH-1:0] evt_async_i = 4'b0000;
  logic          evt_valid_o;
  logic [IW-1:0] evt_id_o;
  logic          evt_ready_i = 1'b0;
  logic [CH-1:0] pend_o;
  logic [CH-1:0] ovf_o;
  logic          ovf_clr_i = 1'b0;

  int vec_cnt     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int xfer_cnt    = 0;

  logic [IW-1:0] exp_q[$];
  int            xfer_cyc_q[$];

  sync_event_arbiter #(.CH_NUM(CH), .SYNC_STAGES(SS), .ID_WIDTH(IW)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .evt_async_i(evt_async_i),
    .evt_valid_o(evt_valid_o),
    .evt_id_o   (evt_id_o),
    .evt_ready_i(evt_ready_i),
    .pend_o     (pend_o),
    .ovf_o      (ovf_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // One clock: look for a transfer at the negedge, then step past the posedge.
  task automatic tick();
    logic [IW-1:0] e;
    @(negedge clk_i);
    if (rst_n_i === 1'b1 && evt_valid_o === 1'b1 && evt_ready_i === 1'b1) begin
      xfer_cnt++;
      xfer_cyc_q.push_back(cyc);
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: transfer id=%0d, expected no transfer", evt_id_o);
      end else begin
        e = exp_q.pop_front();
        if (evt_id_o !== e) begin
          miscompares++;
          $display("FAIL sb_order: got id=%0d, expected id=%0d", evt_id_o, e);
        end
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && evt_valid_o !== 1'b1; i++) tick();
    vec_cnt++;
    if (evt_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_valid: valid=%b after %0d cycles, expected 1", evt_valid_o, max);
    end
  endtask

  task automatic check_sb_empty(input string name);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected transfers missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    evt_ready_i = 1'b0;
    drain(2);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if ({evt_valid_o, evt_id_o, pend_o, ovf_o} !== {1'b0, 2'd0, 4'b0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b id=%0d pend=%b ovf=%b, expected 0/0/0000/0000",
               evt_valid_o, evt_id_o, pend_o, ovf_o);
    end
  endtask

  // ch1 rises: valid appears on the 4th posedge counting the sampling edge.
  task automatic test_latency();
    logic [3:0] exp_valid;
    exp_valid = 4'b1000;
    evt_ready_i = 1'b1;
    evt_async_i = 4'b0010;
    exp_q.push_back(2'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++;
      if (evt_valid_o !== exp_valid[i]) begin
        miscompares++;
        $display("FAIL latency_valid: posedge %0d valid=%b, expected %b", i + 1, evt_valid_o, exp_valid[i]);
      end
    end
    vec_cnt++;
    if (evt_id_o !== 2'd1) begin
      miscompares++;
      $display("FAIL latency_id: got id=%0d, expected 1", evt_id_o);
    end
    tick();
    vec_cnt++;
    if (pend_o[1] !== 1'b0 || evt_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_clear: pend=%b valid=%b, expected pend[1]=0 valid=0", pend_o, evt_valid_o);
    end
    check_sb_empty("latency_sb");
    evt_async_i = 4'b0000;
    drain(4);
  endtask

  // All channels rise together from rr_ptr=0: grants 0,1,2,3 two cycles apart.
  task automatic test_all_same();
    xfer_cyc_q.delete();
    evt_ready_i = 1'b1;
    evt_async_i = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(IW'(i));
    drain(16);
    check_sb_empty("all_same_sb");
    vec_cnt++;
    if (xfer_cyc_q.size() != 4) begin
      miscompares++;
      $display("FAIL all_same_count: %0d transfers, expected 4", xfer_cyc_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        vec_cnt++;
        if (xfer_cyc_q[i] - xfer_cyc_q[i-1] != 2) begin
          miscompares++;
          $display("FAIL all_same_spacing: gap=%0d, expected 2", xfer_cyc_q[i] - xfer_cyc_q[i-1]);
        end
      end
    end
    vec_cnt++;
    if (pend_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL all_same_pend: pend=%b, expected 0000", pend_o);
    end
    evt_async_i = 4'b0000;
    drain(4);
  endtask

  // Move rr_ptr to 2 via a ch1 grant, then ch0+ch3 must go 3 before 0.
  task automatic test_rr_wrap();
    evt_ready_i = 1'b1;
    evt_async_i = 4'b0010;
    exp_q.push_back(2'd1);
    drain(8);
    evt_async_i = 4'b0000;
    drain(4);
    check_sb_empty("rr_setup_sb");
    evt_async_i = 4'b1001;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    drain(10);
    check_sb_empty("rr_wrap_sb");
    evt_async_i = 4'b0000;
    drain(4);
  endtask

  // Stall an offer, check stability, then force an overflow and clear it.
  task automatic test_stall_ovf();
    evt_ready_i = 1'b0;
    evt_async_i = 4'b0100;
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      tick();
      vec_cnt++;
      if ({evt_valid_o, evt_id_o} !== {1'b1, 2'd2}) begin
        miscompares++;
        $display("FAIL stall_hold: valid=%b id=%0d, expected 1/2", evt_valid_o, evt_id_o);
      end
    end
    evt_async_i = 4'b0000;
    drain(4);
    evt_async_i = 4'b0100;
    drain(4);
    vec_cnt++;
    if ({ovf_o, pend_o} !== {4'b0100, 4'b0100}) begin
      miscompares++;
      $display("FAIL stall_ovf: ovf=%b pend=%b, expected 0100/0100", ovf_o, pend_o);
    end
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    vec_cnt++;
    if (ovf_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL ovf_clear: ovf=%b, expected 0000", ovf_o);
    end
    evt_ready_i = 1'b1;
    exp_q.push_back(2'd2);
    drain(3);
    check_sb_empty("stall_sb");
    vec_cnt++;
    if (pend_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL stall_pend: pend=%b, expected 0000", pend_o);
    end
    evt_async_i = 4'b0000;
    drain(4);
  endtask

  // A rise on ch1 detected in the very cycle ch1 is transferred.
  task automatic test_coincide();
    evt_ready_i = 1'b0;
    evt_async_i = 4'b0010;
    wait_valid(10);
    evt_async_i = 4'b0000;
    drain(4);
    evt_async_i = 4'b0010;
    drain(2);
    evt_ready_i = 1'b1;
    exp_q.push_back(2'd1);
    tick();
    vec_cnt++;
    if ({pend_o[1], ovf_o[1]} !== 2'b10) begin
      miscompares++;
      $display("FAIL coincide_flags: pend=%b ovf=%b, expected pend[1]=1 ovf[1]=0", pend_o, ovf_o);
    end
    exp_q.push_back(2'd1);
    drain(4);
    check_sb_empty("coincide_sb");
    vec_cnt++;
    if ({pend_o, ovf_o} !== {4'b0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL coincide_end: pend=%b ovf=%b, expected 0000/0000", pend_o, ovf_o);
    end
    evt_async_i = 4'b0000;
    drain(4);
  endtask

  // Reset during a stalled offer; held-high input gives exactly one event after.
  task automatic test_reset_mid_offer();
    int base;
    evt_ready_i = 1'b0;
    evt_async_i = 4'b1000;
    wait_valid(10);
    evt_async_i = 4'b0000;
    drain(4);
    evt_async_i = 4'b1000;
    drain(4);
    vec_cnt++;
    if (ovf_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL rst_pre_ovf: ovf=%b, expected 1000", ovf_o);
    end
    rst_n_i = 1'b0;
    #1;
    vec_cnt++;
    if ({evt_valid_o, pend_o, ovf_o} !== {1'b0, 4'b0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL rst_mid_offer: valid=%b pend=%b ovf=%b, expected 0/0000/0000",
               evt_valid_o, pend_o, ovf_o);
    end
    drain(2);
    rst_n_i = 1'b1;
    evt_ready_i = 1'b1;
    base = xfer_cnt;
    exp_q.push_back(2'd3);
    drain(12);
    check_sb_empty("rst_release_sb");
    vec_cnt++;
    if (xfer_cnt - base != 1) begin
      miscompares++;
      $display("FAIL rst_release_count: %0d transfers, expected 1", xfer_cnt - base);
    end
    evt_async_i = 4'b0000;
    drain(4);
  endtask

  initial begin
    test_reset();
    test_latency();
    do_reset();
    test_all_same();
    test_rr_wrap();
    test_stall_ovf();
    test_coincide();
    test_reset_mid_offer();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
